// File: rtl/traffic_ctrl.sv
// Traffic light controller: timed RED/GREEN/YELLOW cycle with a pedestrian
// request that shortens GREEN, a flash mode, and an all-red clearance phase.
module traffic_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int T_RED     = 5,
  parameter int T_GREEN   = 5,
  parameter int T_YELLOW  = 2,
  parameter int T_ALLRED  = 1,
  parameter int MIN_GREEN = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_enable,
  input  logic       i_ped_req,
  input  logic       i_flash_mode,
  output logic       o_red,
  output logic       o_yellow,
  output logic       o_green,
  output logic       o_blink_start,
  output logic [2:0] o_state,
  output logic [3:0] o_sec_left
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RED    = 3'd1,
    GREEN  = 3'd2,
    YELLOW = 3'd3,
    ALLRED = 3'd4,
    FLASH  = 3'd5
  } state_t;

  localparam logic [25:0] PRESC_MAX = 26'(CLK_HZ - 1);
  localparam logic [3:0]  SEC_RED    = 4'(T_RED);
  localparam logic [3:0]  SEC_GREEN  = 4'(T_GREEN);
  localparam logic [3:0]  SEC_YELLOW = 4'(T_YELLOW);
  localparam logic [3:0]  SEC_ALLRED = 4'(T_ALLRED);
  localparam logic [4:0]  GREEN_P1   = 5'(T_GREEN + 1);
  localparam logic [4:0]  MIN_G      = 5'(MIN_GREEN);

  state_t      state, state_next;
  logic        ped_sync1, ped_sync2, ped_prev;
  logic        flash_sync1, flash_sync2;
  logic [25:0] presc;
  logic [3:0]  sec_left;
  logic [3:0]  load_val;
  logic        ped_pending;
  logic        ped_rise, counting, tick, phase_change, min_green_met;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ped_sync1   <= 1'b0;
      ped_sync2   <= 1'b0;
      ped_prev    <= 1'b0;
      flash_sync1 <= 1'b0;
      flash_sync2 <= 1'b0;
    end else begin
      ped_sync1   <= i_ped_req;
      ped_sync2   <= ped_sync1;
      ped_prev    <= ped_sync2;
      flash_sync1 <= i_flash_mode;
      flash_sync2 <= flash_sync1;
    end
  end

  assign ped_rise = ped_sync2 & ~ped_prev;
  assign counting = (state == RED) || (state == GREEN) || (state == YELLOW) || (state == ALLRED);
  assign tick     = counting && (presc == PRESC_MAX);
  // Elapsed whole seconds at this tick is T_GREEN - sec_left + 1; rearranged to avoid underflow.
  assign min_green_met = GREEN_P1 >= (MIN_G + {1'b0, sec_left});

  always_comb begin
    state_next = state;
    if (!i_enable) begin
      state_next = IDLE;
    end else if (flash_sync2) begin
      state_next = FLASH;
    end else begin
      case (state)
        IDLE:    state_next = RED;
        RED:     if (tick && sec_left == 4'd1) state_next = GREEN;
        GREEN:   if (tick && (sec_left == 4'd1 || (ped_pending && min_green_met)))
                   state_next = YELLOW;
        YELLOW:  if (tick && sec_left == 4'd1) state_next = RED;
        ALLRED:  if (tick && sec_left == 4'd1) state_next = RED;
        FLASH:   state_next = ALLRED;
        default: state_next = IDLE;
      endcase
    end
  end

  assign phase_change = (state_next != state);

  always_comb begin
    load_val = 4'd0;
    case (state_next)
      RED:     load_val = SEC_RED;
      GREEN:   load_val = SEC_GREEN;
      YELLOW:  load_val = SEC_YELLOW;
      ALLRED:  load_val = SEC_ALLRED;
      default: load_val = 4'd0;
    endcase
  end

  // A ped edge in the same cycle as YELLOW entry wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      presc       <= 26'd0;
      sec_left    <= 4'd0;
      ped_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (phase_change || !counting || tick) presc <= 26'd0;
      else                                   presc <= presc + 26'd1;
      if (phase_change) sec_left <= load_val;
      else if (tick)    sec_left <= sec_left - 4'd1;
      if (!i_enable)                         ped_pending <= 1'b0;
      else if (ped_rise && state != IDLE)    ped_pending <= 1'b1;
      else if (phase_change && state_next == YELLOW) ped_pending <= 1'b0;
    end
  end

  assign o_state       = state;
  assign o_sec_left    = sec_left;
  assign o_red         = !((state == RED) || (state == ALLRED));
  assign o_green       = !(state == GREEN);
  assign o_yellow      = !(state == YELLOW);
  assign o_blink_start = (state == FLASH);

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: vector table, hand-written corner
// sequences and randomized traffic against a cycle-count reference model.
module tb_traffic_ctrl;

  localparam int HZ = 4, TR = 3, TG = 4, TY = 2, TA = 1, MING = 2;
  localparam int S_IDLE = 0, S_RED = 1, S_GREEN = 2, S_YELLOW = 3, S_ALLRED = 4, S_FLASH = 5;

  logic       clk, reset_n, i_enable, i_ped_req, i_flash_mode;
  logic       o_red, o_yellow, o_green, o_blink_start;
  logic [2:0] o_state;
  logic [3:0] o_sec_left;

  int checks = 0;
  int errors = 0;

  // Reference model: phase length tracked in clock cycles, not seconds.
  int       m_state = S_IDLE;
  int       m_rem   = 0;
  logic     m_pend  = 1'b0;
  logic [2:0] ped_h = '0;
  logic [1:0] fl_h  = '0;
  bit       model_valid = 1'b0;

  typedef struct {
    logic rst_n, en, ped, flash;
    int   n;
    int   st;
    int   sec;
    logic [2:0] lamps;
    logic blink;
  } vec_t;
  vec_t vecs[$];

  traffic_ctrl #(.CLK_HZ(HZ), .T_RED(TR), .T_GREEN(TG), .T_YELLOW(TY),
                 .T_ALLRED(TA), .MIN_GREEN(MING)) dut (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_ped_req(i_ped_req),
    .i_flash_mode(i_flash_mode), .o_red(o_red), .o_yellow(o_yellow),
    .o_green(o_green), .o_blink_start(o_blink_start), .o_state(o_state),
    .o_sec_left(o_sec_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int phaseLen(int s);
    case (s)
      S_RED:    return TR * HZ;
      S_GREEN:  return TG * HZ;
      S_YELLOW: return TY * HZ;
      S_ALLRED: return TA * HZ;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [2:0] lampsFor(int s);
    case (s)
      S_RED, S_ALLRED: return 3'b011;
      S_YELLOW:        return 3'b101;
      S_GREEN:         return 3'b110;
      default:         return 3'b111;
    endcase
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep(logic r, logic e, logic p, logic f);
    logic rise, fs;
    int   ns, done_cyc;
    rise = ped_h[1] & ~ped_h[2];
    fs   = fl_h[1];
    if (!r) begin
      ped_h = '0; fl_h = '0;
      m_state = S_IDLE; m_rem = 0; m_pend = 1'b0;
      model_valid = 1'b1;
      return;
    end
    ped_h = {ped_h[1], ped_h[0], p};
    fl_h  = {fl_h[0], f};
    if (!e) begin
      m_state = S_IDLE; m_rem = 0; m_pend = 1'b0;
      return;
    end
    ns = m_state;
    if (fs) ns = S_FLASH;
    else begin
      case (m_state)
        S_IDLE:   ns = S_RED;
        S_RED:    if (m_rem == 1) ns = S_GREEN;
        S_GREEN: begin
          done_cyc = TG * HZ - m_rem + 1;
          if (m_rem == 1 || (m_pend && (done_cyc % HZ == 0) && (done_cyc / HZ >= MING)))
            ns = S_YELLOW;
        end
        S_YELLOW: if (m_rem == 1) ns = S_RED;
        S_ALLRED: if (m_rem == 1) ns = S_RED;
        S_FLASH:  ns = S_ALLRED;
        default:  ns = S_IDLE;
      endcase
    end
    if (rise && m_state != S_IDLE) m_pend = 1'b1;
    else if (ns == S_YELLOW && m_state != S_YELLOW) m_pend = 1'b0;
    if (ns != m_state) m_rem = phaseLen(ns);
    else if (m_rem > 0) m_rem--;
    m_state = ns;
  endtask

  task automatic compareModel();
    if (!model_valid) return;
    checkOutput("model_state", int'(o_state), m_state);
    checkOutput("model_sec_left", int'(o_sec_left), (m_rem + HZ - 1) / HZ);
    checkOutput("model_lamps", int'({o_red, o_yellow, o_green}), int'(lampsFor(m_state)));
    checkOutput("model_blink", int'(o_blink_start), int'(m_state == S_FLASH));
    checkOutput("model_ped_pending", int'(dut.ped_pending), int'(m_pend));
  endtask

  task automatic applyStimulus(logic r, logic e, logic p, logic f);
    reset_n = r; i_enable = e; i_ped_req = p; i_flash_mode = f;
    @(posedge clk);
    modelStep(r, e, p, f);
    #1;
    compareModel();
  endtask

  task automatic addVec(logic r, logic e, logic p, logic f, int n, int st, int sec,
                        logic [2:0] lamps, logic blink);
    vec_t v;
    v.rst_n = r; v.en = e; v.ped = p; v.flash = f; v.n = n;
    v.st = st; v.sec = sec; v.lamps = lamps; v.blink = blink;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitFor(int st, int bound, string name);
    int n = 0;
    while (int'(o_state) != st && n < bound) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput(name, int'(o_state), st);
  endtask

  // Counts samples spent in st, starting at the sample just after entry.
  task automatic countPhase(int st, logic first_ped, output int len);
    bit first = 1'b1;
    len = 0;
    while (int'(o_state) == st && len < 100) begin
      len++;
      applyStimulus(1'b1, 1'b1, first ? first_ped : 1'b0, 1'b0);
      first = 1'b0;
    end
  endtask

  initial begin
    int   len;
    logic rr, ee, pp, ff;
    reset_n = 1'b0; i_enable = 1'b0; i_ped_req = 1'b0; i_flash_mode = 1'b0;

    addVec(0, 0, 0, 0,  2, S_IDLE,   0, 3'b111, 0);
    addVec(1, 1, 0, 0,  1, S_RED,    3, 3'b011, 0);
    addVec(1, 1, 0, 0,  3, S_RED,    3, 3'b011, 0);
    addVec(1, 1, 0, 0,  1, S_RED,    2, 3'b011, 0);
    addVec(1, 1, 0, 0,  4, S_RED,    1, 3'b011, 0);
    addVec(1, 1, 0, 0,  3, S_RED,    1, 3'b011, 0);
    addVec(1, 1, 0, 0,  1, S_GREEN,  4, 3'b110, 0);
    addVec(1, 1, 0, 0, 15, S_GREEN,  1, 3'b110, 0);
    addVec(1, 1, 0, 0,  1, S_YELLOW, 2, 3'b101, 0);
    addVec(1, 1, 0, 0,  7, S_YELLOW, 1, 3'b101, 0);
    addVec(1, 1, 0, 0,  1, S_RED,    3, 3'b011, 0);
    addVec(1, 1, 0, 0, 12, S_GREEN,  4, 3'b110, 0);
    addVec(1, 1, 0, 0,  5, S_GREEN,  3, 3'b110, 0);
    addVec(1, 1, 0, 1,  2, S_GREEN,  3, 3'b110, 0);
    addVec(1, 1, 0, 1,  1, S_FLASH,  0, 3'b111, 1);
    addVec(1, 1, 0, 1,  2, S_FLASH,  0, 3'b111, 1);
    addVec(1, 1, 0, 0,  2, S_FLASH,  0, 3'b111, 1);
    addVec(1, 1, 0, 0,  1, S_ALLRED, 1, 3'b011, 0);
    addVec(1, 1, 0, 0,  3, S_ALLRED, 1, 3'b011, 0);
    addVec(1, 1, 0, 0,  1, S_RED,    3, 3'b011, 0);
    addVec(1, 0, 0, 0,  1, S_IDLE,   0, 3'b111, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++)
        applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].ped, vecs[i].flash);
      checkOutput($sformatf("vec%0d_state", i), int'(o_state), vecs[i].st);
      checkOutput($sformatf("vec%0d_sec", i), int'(o_sec_left), vecs[i].sec);
      checkOutput($sformatf("vec%0d_lamps", i), int'({o_red, o_yellow, o_green}), int'(vecs[i].lamps));
      checkOutput($sformatf("vec%0d_blink", i), int'(o_blink_start), int'(vecs[i].blink));
    end

    // Ped pulse right at GREEN entry cuts GREEN to MIN_GREEN seconds.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitFor(S_GREEN, 30, "ped_entry_wait_green");
    countPhase(S_GREEN, 1'b1, len);
    checkOutput("ped_entry_green_len", len, 8);
    checkOutput("ped_entry_next_state", int'(o_state), S_YELLOW);
    checkOutput("ped_entry_pending_clr", int'(dut.ped_pending), 0);

    // Ped pulse during RED shortens only the next GREEN.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    waitFor(S_GREEN, 30, "ped_red_wait_green1");
    countPhase(S_GREEN, 1'b0, len);
    checkOutput("ped_red_green1_len", len, 8);
    waitFor(S_GREEN, 60, "ped_red_wait_green2");
    countPhase(S_GREEN, 1'b0, len);
    checkOutput("ped_red_green2_len", len, 16);

    // Disable mid-YELLOW, then re-enable for a full RED.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitFor(S_YELLOW, 60, "dis_wait_yellow");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("dis_state", int'(o_state), S_IDLE);
    checkOutput("dis_lamps", int'({o_red, o_yellow, o_green}), 7);
    checkOutput("dis_sec", int'(o_sec_left), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("reen_state", int'(o_state), S_RED);
    countPhase(S_RED, 1'b0, len);
    checkOutput("reen_red_len", len, 12);

    // One-cycle reset mid-GREEN with synchronizers and ped_pending loaded.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitFor(S_GREEN, 30, "rst_wait_green");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_state", int'(o_state), S_IDLE);
    checkOutput("rst_lamps", int'({o_red, o_yellow, o_green}), 7);
    checkOutput("rst_blink", int'(o_blink_start), 0);
    checkOutput("rst_sec", int'(o_sec_left), 0);
    checkOutput("rst_presc", int'(dut.presc), 0);
    checkOutput("rst_pending", int'(dut.ped_pending), 0);
    checkOutput("rst_syncs", int'({dut.ped_sync1, dut.ped_sync2, dut.flash_sync1, dut.flash_sync2}), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_restart_state", int'(o_state), S_RED);
    checkOutput("rst_restart_sec", int'(o_sec_left), 3);

    // Randomized traffic checked cycle by cycle against the model.
    ff = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 199) != 0);
      ee = ($urandom_range(0, 99) != 0);
      pp = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) ff = ~ff;
      applyStimulus(rr, ee, pp, ff);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
